// File: rtl/demux_pkg.sv
// Shared types and default widths for the demux frame sequencer slice.
package demux_pkg;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NUM_CH = 2 ** SEL_W;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;
endpackage

// File: rtl/next_set_bit.sv
// Finds the lowest set mask bit strictly above idx, or the lowest overall when start is high.
module next_set_bit
    import demux_pkg::*;
#(
    parameter int unsigned IDX_W = SEL_W
) (
    input  logic [(2**IDX_W)-1:0] mask,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  start,
    output logic [IDX_W-1:0]      nxt,
    output logic                  found
);
    localparam int unsigned CH = 2 ** IDX_W;

    logic [31:0] idx_u;
    assign idx_u = 32'(idx);

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (!found && mask[i] && (start || i > idx_u)) begin
                found = 1'b1;
                nxt   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/demux_frame_sequencer.sv
// Serialises an accepted frame word onto the 1-to-8 demux inputs, one enabled channel at a time.
module demux_frame_sequencer #(
    parameter int unsigned SEL_W  = demux_pkg::SEL_W,
    parameter int unsigned HOLD_W = demux_pkg::HOLD_W,
    parameter int unsigned CNT_W  = demux_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [(2**SEL_W)-1:0]   in_data,
    input  logic [(2**SEL_W)-1:0]   in_mask,
    input  logic [HOLD_W-1:0]       hold_cycles,
    output logic                    I,
    output logic [SEL_W-1:0]        S,
    output logic                    out_valid,
    output logic                    frame_done,
    output logic                    busy,
    output logic [CNT_W-1:0]        frame_count
);
    import demux_pkg::state_t;
    import demux_pkg::IDLE;
    import demux_pkg::DRIVE;
    import demux_pkg::DONE;

    localparam int unsigned NUM_CH = 2 ** SEL_W;

    state_t              state, state_n;
    logic [NUM_CH-1:0]   data_q, mask_q;
    logic [HOLD_W-1:0]   hold_q, hold_cnt;
    logic [SEL_W-1:0]    idx;
    logic [CNT_W-1:0]    count_q;

    logic                srch_start, srch_found;
    logic [NUM_CH-1:0]   srch_mask;
    logic [SEL_W-1:0]    srch_idx;
    logic                accept, chan_end;

    // In IDLE the search runs on the incoming mask so the first channel is known at accept.
    assign srch_start = (state == IDLE);
    assign srch_mask  = srch_start ? in_mask : mask_q;

    next_set_bit #(.IDX_W(SEL_W)) u_next_set_bit (
        .mask  (srch_mask),
        .idx   (idx),
        .start (srch_start),
        .nxt   (srch_idx),
        .found (srch_found)
    );

    assign S           = idx;
    assign frame_count = count_q;

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        chan_end   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        I          = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) state_n = srch_found ? DRIVE : DONE;
            end
            DRIVE: begin
                out_valid = 1'b1;
                I         = data_q[idx];
                chan_end  = (hold_cnt == '0);
                if (chan_end && !srch_found) state_n = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
            idx      <= '0;
            count_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                data_q   <= in_data;
                mask_q   <= in_mask;
                hold_q   <= hold_cycles;
                hold_cnt <= hold_cycles;
                if (srch_found) idx <= srch_idx;
            end else if (state == DRIVE) begin
                if (chan_end) begin
                    hold_cnt <= hold_q;
                    if (srch_found) idx <= srch_idx;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
            if (state == DONE) count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Scoreboard bench: accepted frames expand into expected per-cycle channel beats checked by a monitor.
module tb_demux_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [7:0] in_mask = '0;
    logic [3:0] hold_cycles = '0;
    logic       I;
    logic [2:0] S;
    logic       out_valid;
    logic       frame_done;
    logic       busy;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    demux_frame_sequencer #(.SEL_W(3), .HOLD_W(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mask     (in_mask),
        .hold_cycles (hold_cycles),
        .I           (I),
        .S           (S),
        .out_valid   (out_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    typedef struct packed {
        bit       done;
        bit [2:0] s;
        bit       i;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned exp_cnt = 0;
    bit          active = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    // Reference: every enabled channel in ascending order for hold+1 beats, then one done beat.
    function automatic void model_push(input logic [7:0] d, input logic [7:0] m, input logic [3:0] h);
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                for (int r = 0; r <= int'(h); r++)
                    expq.push_back(exp_t'{done: 1'b0, s: 3'(k), i: d[k]});
            end
        end
        expq.push_back(exp_t'{done: 1'b1, s: 3'd0, i: 1'b0});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        check("frame_count", frame_count, exp_cnt);
        if (active) check("frame_continuous", out_valid || frame_done, 1);
        if (out_valid || frame_done) begin
            check("busy_with_output", busy, 1);
            if (expq.size() == 0) begin
                check("unexpected_output", {out_valid, frame_done}, 0);
            end else begin
                e = expq.pop_front();
                if (e.done) begin
                    check("done_pulse", frame_done, 1);
                    check("done_valid", out_valid, 0);
                    check("done_I", I, 0);
                    exp_cnt = (exp_cnt + 1) % 256;
                    active  = 1'b0;
                end else begin
                    check("chan_valid", out_valid, 1);
                    check("chan_S", S, e.s);
                    check("chan_I", I, e.i);
                end
            end
        end
        if (rst) begin
            check("ready_in_reset", in_ready, 0);
            expq.delete();
            active  = 1'b0;
            exp_cnt = 0;
        end else if (in_valid && in_ready) begin
            model_push(in_data, in_mask, hold_cycles);
            active = 1'b1;
        end
    end

    // Offers a frame and returns #1 after its accept edge with in_valid still high.
    task automatic send(input logic [7:0] d, input logic [7:0] m, input logic [3:0] h);
        bit ok;
        ok = 1'b0;
        in_data     = d;
        in_mask     = m;
        hold_cycles = h;
        in_valid    = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("accept_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (expq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("idle_wait");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_S"}, S, 0);
        check({tag, "_I"}, I, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        send(8'hA5, 8'hFF, 4'd0);  in_valid = 1'b0; wait_idle();
        send(8'hFF, 8'h81, 4'd2);  in_valid = 1'b0; wait_idle();
        send(8'h6C, 8'h10, 4'd15); in_valid = 1'b0; wait_idle();

        for (int n = 0; n < 4; n++) send(8'($urandom), 8'h00, 4'd3);
        in_valid = 1'b0;
        wait_idle();

        // in_data drops to zero while the all-ones frame is still being serialised
        send(8'hFF, 8'hFF, 4'd0);
        in_data = 8'h00;
        send(8'h00, 8'hFF, 4'd0);
        in_valid = 1'b0;
        wait_idle();

        send(8'h5A, 8'hFF, 4'd1);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid && S == 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("reach_channel4");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midframe_reset");
        rst = 1'b0;
        send(8'hC3, 8'hFF, 4'd0); in_valid = 1'b0; wait_idle();

        for (int n = 0; n < 40; n++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send(8'($urandom), m, 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 12)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        wait_idle();

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 256; n++) send(8'($urandom), 8'h01, 4'd0);
        in_valid = 1'b0;
        wait_idle();
        check("wrap_count", frame_count, 0);
        check("wrap_queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
